// File: rtl/pipeline_arbiter_pkg.sv
// Shared types and constants for the round-robin pipeline arbiter.
// Holds the output-slot state encoding, default widths and the performance counter width.
package pipeline_arbiter_pkg;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int CNT_WIDTH          = 16;

endpackage

// File: rtl/pipeline_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping upward.
// Produces the one-hot grant, its index, and whether any request is set at all.
module rr_priority_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    // NOTE: every output gets a default first so no path leaves a latch behind.
    sum       = '0;
    cand      = '0;
    grant     = '0;
    idx       = '0;
    any_valid = |req;
    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/pipeline_arbiter.sv
// Round-robin arbiter feeding a single registered output slot (EMPTY/FULL, one payload per cycle).
// Define PIPELINE_ARBITER_PERF_EN to add saturating per-requester grant counters on grant_count_o.
module pipeline_arbiter
  import pipeline_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic                                m_data_valid_o,
  output logic [DATA_WIDTH-1:0]               m_data_data_o,
  input  logic                                m_data_ready_i,
  input  logic                                ctrl_stall_i,
  input  logic                                ctrl_flush_i,
  output logic [IDX_W-1:0]                    grant_id_o,
  output logic                                busy_o
`ifdef PIPELINE_ARBITER_PERF_EN
  ,
  output logic [NUM_REQ-1:0][CNT_WIDTH-1:0]   grant_count_o
`endif
);

  arb_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]   slot_q;
  logic [IDX_W-1:0]        grant_id_q;
  logic [IDX_W-1:0]        last_grant_q;
  logic [IDX_W-1:0]        ptr;
  logic [NUM_REQ-1:0]      pick_grant;
  logic [IDX_W-1:0]        pick_idx;
  logic                    any_valid;
  logic                    pop;
  logic                    accept;

  assign ptr = (last_grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : last_grant_q + 1'b1;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req       (req_valid_i),
    .ptr       (ptr),
    .grant     (pick_grant),
    .idx       (pick_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    state_d = state_q;
    pop     = (state_q == ARB_FULL) && m_data_ready_i && !ctrl_stall_i && !ctrl_flush_i;
    // Reset is synchronous, so handshakes are masked combinationally during the reset cycle.
    accept  = ((state_q == ARB_EMPTY) || pop) && any_valid
              && !ctrl_stall_i && !ctrl_flush_i && !rst_i;
    if (ctrl_flush_i)  state_d = ARB_EMPTY;
    else if (accept)   state_d = ARB_FULL;
    else if (pop)      state_d = ARB_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ARB_EMPTY;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q       <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else if (ctrl_flush_i) begin
      slot_q <= '0;
    end else if (accept) begin
      slot_q       <= req_data_i[pick_idx];
      grant_id_q   <= pick_idx;
      last_grant_q <= pick_idx;
    end
  end

`ifdef PIPELINE_ARBITER_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_count_o <= '0;
    end else if (accept && (grant_count_o[pick_idx] != '1)) begin
      grant_count_o[pick_idx] <= grant_count_o[pick_idx] + 1'b1;
    end
  end
`endif

  assign req_ready_o    = accept ? pick_grant : '0;
  assign m_data_valid_o = (state_q == ARB_FULL) && !ctrl_stall_i && !ctrl_flush_i && !rst_i;
  assign m_data_data_o  = m_data_valid_o ? slot_q : '0;
  assign grant_id_o     = grant_id_q;
  assign busy_o         = (state_q == ARB_FULL);

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Bench for pipeline_arbiter: vector table plus a payload scoreboard, a random back-pressure stream,
// and (with PIPELINE_ARBITER_PERF_EN defined) the grant counter saturation run.
module tb_pipeline_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic             m_valid;
  logic [31:0]      m_data;
  logic             m_ready;
  logic             stall;
  logic             flush;
  logic [1:0]       grant_id;
  logic             busy;
`ifdef PIPELINE_ARBITER_PERF_EN
  logic [3:0][15:0] grant_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  pipeline_arbiter dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .m_data_valid_o (m_valid),
    .m_data_data_o  (m_data),
    .m_data_ready_i (m_ready),
    .ctrl_stall_i   (stall),
    .ctrl_flush_i   (flush),
    .grant_id_o     (grant_id),
    .busy_o         (busy)
`ifdef PIPELINE_ARBITER_PERF_EN
    ,
    .grant_count_o  (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       mready;
    logic       stall;
    logic       flush;
    logic [3:0] exp_ready;
    logic       exp_mvalid;
    logic [1:0] exp_gid;
    logic       gid_care;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(logic r, logic [3:0] v, logic mr, logic s, logic f,
                              logic [3:0] er, logic ev, logic [1:0] eg, logic gc, logic eb);
    vec_t t;
    t.rst = r; t.valid = v; t.mready = mr; t.stall = s; t.flush = f;
    t.exp_ready = er; t.exp_mvalid = ev; t.exp_gid = eg; t.gid_care = gc; t.exp_busy = eb;
    return t;
  endfunction

  function automatic logic [31:0] data_of(int i);
    case (i)
      0:       return 32'h1111_1111;
      1:       return 32'h2222_2222;
      2:       return 32'hA5A5_A5A5;
      default: return 32'h4444_4444;
    endcase
  endfunction

  function automatic int oh2idx(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_data(input string name, input logic do_pop);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      check(name, m_data, sb_q[0]);
      if (do_pop) void'(sb_q.pop_front());
    end
  endtask

  task automatic apply_row(input int n, input vec_t v);
    string tag;
    tag       = $sformatf("row%0d", n);
    rst       = v.rst;
    req_valid = v.valid;
    m_ready   = v.mready;
    stall     = v.stall;
    flush     = v.flush;
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'(v.exp_ready));
    check({tag, "_m_valid"},   32'(m_valid),   32'(v.exp_mvalid));
    check({tag, "_busy"},      32'(busy),      32'(v.exp_busy));
    if (v.gid_care) check({tag, "_grant_id"}, 32'(grant_id), 32'(v.exp_gid));
    if (v.rst) begin
      sb_q.delete();
    end else if (v.flush && v.exp_busy && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    if (v.exp_mvalid) check_data({tag, "_m_data"}, v.mready);
    else              check({tag, "_m_data_zero"}, m_data, 32'd0);
    if (v.exp_ready != 4'd0) sb_q.push_back(data_of(oh2idx(v.exp_ready)));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) req_data[i] = data_of(i);
    rst = 1'b1; req_valid = '0; m_ready = 1'b0; stall = 1'b0; flush = 1'b0;

    // Round-robin stream, held payload under back-pressure, stall, flush+stall, reset while FULL.
    vecs[0]  = mk(0, 4'b1111, 1, 0, 0, 4'b0001, 0, 0, 1, 0);
    vecs[1]  = mk(0, 4'b1111, 1, 0, 0, 4'b0010, 1, 0, 1, 1);
    vecs[2]  = mk(0, 4'b1111, 1, 0, 0, 4'b0100, 1, 1, 1, 1);
    vecs[3]  = mk(0, 4'b1111, 1, 0, 0, 4'b1000, 1, 2, 1, 1);
    vecs[4]  = mk(0, 4'b1111, 1, 0, 0, 4'b0001, 1, 3, 1, 1);
    vecs[5]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 1, 1);
    vecs[6]  = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 1, 0);
    vecs[7]  = mk(0, 4'b0100, 0, 0, 0, 4'b0100, 0, 0, 1, 0);
    vecs[8]  = mk(0, 4'b0100, 0, 0, 0, 4'b0000, 1, 2, 1, 1);
    vecs[9]  = mk(0, 4'b0100, 0, 0, 0, 4'b0000, 1, 2, 1, 1);
    vecs[10] = mk(0, 4'b0100, 0, 0, 0, 4'b0000, 1, 2, 1, 1);
    vecs[11] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 2, 1, 1);
    vecs[12] = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2, 1, 0);
    vecs[13] = mk(0, 4'b0010, 0, 0, 0, 4'b0010, 0, 2, 1, 0);
    vecs[14] = mk(0, 4'b1111, 1, 1, 0, 4'b0000, 0, 1, 1, 1);
    vecs[15] = mk(0, 4'b1111, 1, 1, 0, 4'b0000, 0, 1, 1, 1);
    vecs[16] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 1, 1, 1);
    vecs[17] = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 1, 1, 0);
    vecs[18] = mk(0, 4'b1000, 0, 0, 0, 4'b1000, 0, 1, 1, 0);
    vecs[19] = mk(0, 4'b1111, 1, 1, 1, 4'b0000, 0, 3, 1, 1);
    vecs[20] = mk(0, 4'b1111, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
    vecs[21] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 1, 1);
    vecs[22] = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
    vecs[23] = mk(0, 4'b1000, 0, 0, 0, 4'b1000, 0, 0, 1, 0);
    vecs[24] = mk(1, 4'b0100, 1, 0, 0, 4'b0000, 0, 3, 1, 1);
    vecs[25] = mk(0, 4'b0100, 1, 0, 0, 4'b0100, 0, 0, 1, 0);
    vecs[26] = mk(0, 4'b0000, 1, 0, 0, 4'b0000, 1, 2, 1, 1);
    vecs[27] = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2, 1, 0);

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 28; i++) apply_row(i, vecs[i]);

    // All requesters valid under random back-pressure; winners must keep rotating (last grant was 2).
    begin
      logic busy_m;
      int   nxt;
      logic pop_m, acc_m;
      busy_m = 1'b0;
      nxt    = 3;
      sb_q.delete();
      for (int c = 0; c < 40; c++) begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; req_valid = 4'b1111;
        m_ready = 1'($urandom_range(0, 1));
        #1;
        pop_m = busy_m && m_ready;
        acc_m = !busy_m || pop_m;
        check($sformatf("rnd%0d_req_ready", c), 32'(req_ready), acc_m ? (32'd1 << nxt) : 32'd0);
        check($sformatf("rnd%0d_m_valid", c), 32'(m_valid), 32'(busy_m));
        if (pop_m) check_data($sformatf("rnd%0d_m_data", c), 1'b1);
        if (acc_m) begin
          sb_q.push_back(data_of(nxt));
          nxt = (nxt + 1) % 4;
        end
        busy_m = acc_m ? 1'b1 : (pop_m ? 1'b0 : busy_m);
        @(negedge clk);
      end
    end

`ifdef PIPELINE_ARBITER_PERF_EN
    rst = 1'b1; req_valid = '0; m_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0001; m_ready = 1'b1;
    repeat (70000) @(negedge clk);
    req_valid = '0;
    #1;
    check("perf_count0_sat", 32'(grant_count[0]), 32'h0000_FFFF);
    check("perf_count1",     32'(grant_count[1]), 32'd0);
    check("perf_count2",     32'(grant_count[2]), 32'd0);
    check("perf_count3",     32'(grant_count[3]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_arbiter.md
PIPELINE_ARBITER -- requirements
Module: pipeline_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-003 The block SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid_i  input  NUM_REQ  per-requester valid.
REQ-006 The block SHALL have port req_data_i  input  NUM_REQ x DATA_WIDTH  per-requester payload.
REQ-007 The block SHALL have port req_ready_o  output  NUM_REQ  per-requester ready, one-hot or zero.
REQ-008 The block SHALL have port m_data_valid_o  output  1  output valid toward the downstream pipeline register.
REQ-009 The block SHALL have port m_data_data_o  output  DATA_WIDTH  output payload.
REQ-010 The block SHALL have port m_data_ready_i  input  1  downstream ready.
REQ-011 The block SHALL have port ctrl_stall_i  input  1  external stall.
REQ-012 The block SHALL have port ctrl_flush_i  input  1  external flush.
REQ-013 The block SHALL have port grant_id_o  output  $clog2(NUM_REQ)  index of the requester owning the held payload.
REQ-014 The block SHALL have port busy_o  output  1  high while a payload is held.

Function
REQ-015 The block SHALL hold exactly one payload in a registered output slot with two states, EMPTY and FULL.
REQ-016 pop SHALL be FULL && m_data_ready_i && ~ctrl_stall_i && ~ctrl_flush_i.
REQ-017 accept SHALL be (EMPTY || pop) && any req_valid_i && ~ctrl_stall_i && ~ctrl_flush_i.
REQ-018 On accept, the winner SHALL be the first valid requester at or after index (last_grant+1) mod NUM_REQ, searching upward with wrap-around.
REQ-019 req_ready_o SHALL be asserted only for the winner and only in an accept cycle, combinationally from the same-cycle inputs.
REQ-020 On accept, the slot SHALL capture req_data_i[winner], grant_id_o SHALL become winner, and last_grant SHALL become winner, all at the next edge.
REQ-021 Transitions SHALL be: EMPTY->FULL on accept; FULL->EMPTY on pop without accept; FULL->FULL on pop with accept (back-to-back, one payload per cycle); otherwise the state SHALL be held.
REQ-022 Latency SHALL be one cycle from accept to m_data_valid_o.
REQ-023 m_data_valid_o SHALL equal FULL && ~ctrl_stall_i && ~ctrl_flush_i.
REQ-024 m_data_data_o SHALL be zero whenever m_data_valid_o is low.
REQ-025 While stalled, the held payload, grant_id_o and last_grant SHALL be unchanged.
REQ-026 Flush SHALL force EMPTY at the next edge, discard the held payload, clear the slot to zero, and leave last_grant unchanged; flush SHALL take precedence over stall.
REQ-027 busy_o SHALL equal FULL (registered) and SHALL be unaffected combinationally by stall or flush.
REQ-028 The payload, once captured, SHALL stay stable until popped or flushed, with no grant preemption.

Reset
REQ-029 When rst_i is high at a clock edge, the block SHALL enter EMPTY, with slot=0, grant_id_o=0, last_grant=NUM_REQ-1 (requester 0 highest priority), and all counters cleared.
REQ-030 Reset SHALL override flush, stall and accept in the same cycle; during reset, req_ready_o and m_data_valid_o SHALL be 0.

Configuration
REQ-031 With macro PIPELINE_ARBITER_PERF_EN defined, the block SHALL add output grant_count_o (NUM_REQ x 16), where entry i increments on each accept of i, saturates at 0xFFFF, and is cleared only by reset.
REQ-032 Without PIPELINE_ARBITER_PERF_EN, the port and counters SHALL be absent, with behaviour otherwise identical.

Structure
REQ-033 Package pipeline_arbiter_pkg SHALL hold the state enum (ARB_EMPTY, ARB_FULL), the default widths, and the counter width constant (16).
REQ-034 Sub-module rr_priority_picker SHALL hold the combinational search: inputs are the request vector and the pointer; outputs are the one-hot grant, the index, and any_valid.

Verification
REQ-035 Reset then req_valid_i=4'b1111 held, m_data_ready_i=1 -> grant_id_o sequence 0,1,2,3,0; one valid output per cycle after 1-cycle latency.
REQ-036 Requester 2 only valid, data 0xA5A5A5A5, m_data_ready_i=0 for 3 cycles -> valid high with data held 3 cycles, req_ready_o=0 throughout; pops on ready; busy_o falls next cycle.
REQ-037 FULL with grant 1, ctrl_stall_i=1 for 2 cycles with all requesters valid -> m_data_valid_o=0, req_ready_o=0, grant_id_o=1 held; resumes delivering payload 1 afterwards.
REQ-038 FULL with grant 3 and last_grant=3, ctrl_flush_i=1 with ctrl_stall_i=1 -> next cycle EMPTY, busy_o=0, payload lost; next accept with all valid grants 0.
REQ-039 rst_i asserted while FULL and req_valid_i=4'b0100 -> next cycle EMPTY, grant_id_o=0, m_data_valid_o=0; first post-reset grant goes to requester 2.
REQ-040 PIPELINE_ARBITER_PERF_EN defined, requester 0 granted 70000 times -> grant_count_o[0]=0xFFFF; the other counters unchanged.
